rr_mux4: RTL and testbench
==========================

Name: rr_mux4

Overview:
- 4-to-1 merging multiplexer with round-robin arbitration and packet locking; the converging counterpart to the 1x4 demux.
- Merges four valid/ready input channels into one registered output stream.
- Output carries a 2-bit source index `sel`, using the same index encoding the demux uses for its select inputs (index i = channel i), so a downstream demux can route by it directly.
- Sits at the merge point of four producers sharing one consumer.

Parameters:
WIDTH, 8, data width of each input channel and of the output

Ports:
clk      input   1      clock, all state on rising edge
rst      input   1      asynchronous active-high reset
in0      input   WIDTH  channel 0 data
in1      input   WIDTH  channel 1 data
in2      input   WIDTH  channel 2 data
in3      input   WIDTH  channel 3 data
vld      input   4      per-channel valid, bit i = channel i
last     input   4      per-channel end-of-packet marker, qualified by vld[i]
rdy      output  4      per-channel ready, bit i = channel i
out      output  WIDTH  registered output data
out_vld  output  1      output valid
out_last output  1      registered end-of-packet marker of current output word
out_rdy  input   1      downstream ready
sel      output  2      source index of current output word

Behaviour:
- Reset (async, rst=1): out=0, out_vld=0, out_last=0, sel=0, state=IDLE, rr pointer ptr=3 (channel 0 highest priority first), rdy=0 while rst high.
- load = ~out_vld | out_rdy; the one-entry output register may accept a new word this cycle.
- States:
  - IDLE: no packet in progress.
  - LOCK: packet from channel lk in progress.
- Grant:
  - IDLE: first i with vld[i]=1, scanning ptr+1, ptr+2, ptr+3, ptr+4 (mod 4).
  - LOCK: lk only, and only if vld[lk]=1.
  - At most one grant per cycle.
- rdy[i] = load & grant==i & vld[i]. This is combinational from vld/state/out_rdy; no register in the rdy path.
- Transfer on channel i when vld[i] & rdy[i]. Next edge:
  - out <= in_i
  - out_last <= last[i]
  - sel <= i
  - out_vld <= 1
  - If last[i]=1: state <= IDLE, ptr <= i.
  - If last[i]=0: state <= LOCK, lk <= i.
- load=1 and no transfer: out_vld <= 0; out, out_last and sel hold their last values.
- load=0 (out_vld=1, out_rdy=0): all registers hold, rdy=0.
- Throughput: 1 word/cycle with out_rdy held 1. Latency: input transfer to out_vld is 1 cycle.
- Single-beat packets (last=1 on first beat) are legal. Arbitration moves after every beat.
- LOCK with vld[lk]=0 (bubble): no grant to any channel and the lock is held. Other channels starve until lk delivers last.
- ptr updates only on last-beat transfer, never mid-packet.
- Input data/last for non-granted channels is ignored. X on non-valid channels must not propagate to out.
- Reset mid-packet: lock and output word are dropped immediately. Restart in IDLE with ptr=3.

Test Plan:
- Reset: rst=1 with all vld=1 -> out_vld=0, out=0, sel=0, rdy=0000. Release rst with vld=0001, out_rdy=1 -> rdy=0001.
- Single word: vld=0100, in2=8'hA5, last=0100, out_rdy=1 -> next cycle out=8'hA5, sel=2, out_vld=1, out_last=1. Following cycle with vld=0 -> out_vld=0.
- Fairness: vld=1111, last=1111, out_rdy=1 held 8 cycles -> sel sequence 0,1,2,3,0,1,2,3 on consecutive cycles, out_vld stays 1.
- Packet lock: ch1 sends 3 beats 11,12,13 (last on 13) while vld[0]=1 -> sel=1 for three output words, rdy[0]=0 throughout; next word from ch0 (sel=0).
- Backpressure: out_vld=1 with out=8'h33, out_rdy=0 for 3 cycles, vld=0010 -> out holds 8'h33, rdy=0000. On out_rdy=1, rdy[1]=1 that cycle and the ch1 word appears the next cycle with no bubble.
- Reset mid-packet: ch3 locked after 2 of 4 beats, pulse rst -> out_vld=0 immediately. After release with vld=1001, first grant is ch0.

Source files
------------

// File: rtl/rr_mux4.sv
// rr_mux4: four valid/ready producers merged into one registered output stream.
// Round-robin arbitration between packets; a granted channel keeps the output until its last beat.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no packet in progress, round-robin scan from ptr+1 picks winner
// LOCK  | packet from channel lk in progress, only lk may transfer
module rr_mux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [3:0]       vld,
  input  logic [3:0]       last,
  output logic [3:0]       rdy,
  output logic [WIDTH-1:0] out,
  output logic             out_vld,
  output logic             out_last,
  input  logic             out_rdy,
  output logic [1:0]       sel
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [1:0]       lk, lk_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             out_vld_nxt;
  logic             out_last_nxt;
  logic [1:0]       sel_nxt;

  logic             load;
  logic             gnt_vld;
  logic [1:0]       gnt;
  logic [1:0]       idx;
  logic             xfer;
  logic [WIDTH-1:0] gnt_data;
  logic             gnt_last;

  assign load = ~out_vld | out_rdy;

  // Grant selection: a held lock never falls back to the scan, even when lk has a bubble.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 2'd0;
    idx     = 2'd0;
    if (state == LOCK) begin
      if (vld[lk]) begin
        gnt_vld = 1'b1;
        gnt     = lk;
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        idx = ptr + 2'(k);
        if (!gnt_vld && vld[idx]) begin
          gnt_vld = 1'b1;
          gnt     = idx;
        end
      end
    end
  end

  // rdy is gated by rst so nothing is accepted while reset is asserted.
  assign rdy  = (load && gnt_vld && !rst) ? (4'b0001 << gnt) : 4'b0000;
  assign xfer = |(vld & rdy);

  always_comb begin
    gnt_data = in0;
    gnt_last = last[0];
    case (gnt)
      2'd0: begin gnt_data = in0; gnt_last = last[0]; end
      2'd1: begin gnt_data = in1; gnt_last = last[1]; end
      2'd2: begin gnt_data = in2; gnt_last = last[2]; end
      2'd3: begin gnt_data = in3; gnt_last = last[3]; end
      default: begin gnt_data = in0; gnt_last = last[0]; end
    endcase
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    lk_nxt       = lk;
    out_nxt      = out;
    out_vld_nxt  = out_vld;
    out_last_nxt = out_last;
    sel_nxt      = sel;
    if (xfer) begin
      out_nxt      = gnt_data;
      out_last_nxt = gnt_last;
      sel_nxt      = gnt;
      out_vld_nxt  = 1'b1;
      if (gnt_last) begin
        state_nxt = IDLE;
        ptr_nxt   = gnt;
      end else begin
        state_nxt = LOCK;
        lk_nxt    = gnt;
      end
    end else if (load) begin
      out_vld_nxt = 1'b0;
    end
  end

  // ptr resets to 3 so the first scan starts at channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 2'd3;
      lk       <= 2'd0;
      out      <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      sel      <= 2'd0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      lk       <= lk_nxt;
      out      <= out_nxt;
      out_vld  <= out_vld_nxt;
      out_last <= out_last_nxt;
      sel      <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_rr_mux4.sv
// Bench for rr_mux4: directed scenarios plus random traffic against a packet-level reference model.
module tb_rr_mux4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din [4];
  logic [3:0] vld = 4'b0;
  logic [3:0] last = 4'b0;
  logic [3:0] rdy;
  logic [7:0] out;
  logic       out_vld;
  logic       out_last;
  logic       out_rdy = 1'b0;
  logic [1:0] sel;

  int checks = 0;
  int errors = 0;

  // reference model: owner is the channel holding the output mid-packet (-1 = none),
  // prev_win is the channel whose packet finished most recently
  int         owner;
  int         prev_win;
  logic       m_vld;
  logic [7:0] m_out;
  logic       m_last;
  int         m_sel;

  rr_mux4 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .vld(vld), .last(last), .rdy(rdy),
    .out(out), .out_vld(out_vld), .out_last(out_last),
    .out_rdy(out_rdy), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (owner >= 0) return vld[owner] ? owner : -1;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (prev_win + k) % 4;
      if (vld[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    owner = -1; prev_win = 3; m_vld = 1'b0; m_out = 8'h00; m_last = 1'b0; m_sel = 0;
  endtask

  // one clock: check rdy before the edge, predict, then check registered outputs after it
  task automatic step();
    int g;
    logic ld;
    logic [3:0] exp_rdy;
    #1;
    g = model_grant();
    ld = !m_vld || out_rdy;
    exp_rdy = (ld && g >= 0) ? 4'(1 << g) : 4'b0000;
    chk("rdy", 32'(rdy), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (ld && g >= 0) begin
      m_vld = 1'b1; m_out = din[g]; m_last = last[g]; m_sel = g;
      if (last[g]) begin owner = -1; prev_win = g; end
      else owner = g;
    end else if (ld) begin
      m_vld = 1'b0;
    end
    chk("out_vld", 32'(out_vld), 32'(m_vld));
    if (m_vld) begin
      chk("out", 32'(out), 32'(m_out));
      chk("sel", 32'(sel), 32'(m_sel));
      chk("out_last", 32'(out_last), 32'(m_last));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
    model_reset();

    // reset with all channels requesting
    vld = 4'b1111; last = 4'b1111; out_rdy = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd0);
    vld = 4'b0001; last = 4'b0001; din[0] = 8'h5A;
    rst = 1'b0;
    #1;
    chk("rel_rdy", 32'(rdy), 32'b0001);
    step();

    // single word from ch2
    vld = 4'b0100; last = 4'b0100; din[2] = 8'hA5;
    step();
    chk("single_out", 32'(out), 32'hA5);
    chk("single_sel", 32'(sel), 32'd2);
    chk("single_last", 32'(out_last), 32'd1);
    vld = 4'b0000;
    step();
    chk("single_drain", 32'(out_vld), 32'd0);

    // fairness from a fresh reset
    do_reset();
    vld = 4'b1111; last = 4'b1111; out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 4; c++) din[c] = 8'(16 * c + i);
      step();
      chk("fair_sel", 32'(sel), 32'(i % 4));
      chk("fair_vld", 32'(out_vld), 32'd1);
    end

    // packet lock on ch1 with ch0 contending; ptr is currently 3 so ch0 goes first
    vld = 4'b0001; last = 4'b0001; din[0] = 8'h01;
    step();
    for (int b = 0; b < 3; b++) begin
      vld = 4'b0011; din[0] = 8'h0F; din[1] = 8'(11 + b);
      last = (b == 2) ? 4'b0011 : 4'b0001;
      if (b == 0) begin
        // ch0 just won, so ch1 is first in the scan
        #1; chk("lock_rdy0", 32'(rdy[0]), 32'd0);
      end
      step();
      chk("lock_sel", 32'(sel), 32'd1);
      chk("lock_out", 32'(out), 32'(11 + b));
    end
    vld = 4'b0001; last = 4'b0001; din[0] = 8'h20;
    step();
    chk("lock_after_sel", 32'(sel), 32'd0);

    // lock bubble: ch2 mid-packet stalls while ch3 waits
    vld = 4'b0100; last = 4'b0000; din[2] = 8'h44;
    step();
    vld = 4'b1000; last = 4'b1000; din[3] = 8'h77;
    step();
    chk("bubble_rdy", 32'(rdy), 32'd0);
    vld = 4'b1100; last = 4'b1100; din[2] = 8'h45;
    step();
    chk("bubble_sel", 32'(sel), 32'd2);

    // backpressure
    vld = 4'b0010; last = 4'b0010; din[1] = 8'h33;
    step();
    out_rdy = 1'b0; din[1] = 8'h34;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_out", 32'(out), 32'h33);
      chk("bp_rdy", 32'(rdy), 32'd0);
    end
    out_rdy = 1'b1;
    #1; chk("bp_release_rdy", 32'(rdy), 32'b0010);
    step();
    chk("bp_next_out", 32'(out), 32'h34);
    chk("bp_next_vld", 32'(out_vld), 32'd1);

    // reset mid-packet on ch3
    do_reset();
    vld = 4'b1000; last = 4'b0000; out_rdy = 1'b1;
    for (int b = 0; b < 2; b++) begin
      din[3] = 8'(8'hC0 + b);
      step();
    end
    rst = 1'b1;
    #1;
    chk("midrst_out_vld", 32'(out_vld), 32'd0);
    chk("midrst_rdy", 32'(rdy), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    vld = 4'b1001; last = 4'b1001; din[0] = 8'hD0; din[3] = 8'hD3;
    #1; chk("midrst_grant", 32'(rdy), 32'b0001);
    step();
    chk("midrst_sel", 32'(sel), 32'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      vld = 4'($urandom);
      last = 4'($urandom) | 4'($urandom);
      out_rdy = ($urandom_range(0, 9) < 7);
      for (int c = 0; c < 4; c++) din[c] = 8'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
